mips32_prefetch_queue: RTL

Instruction prefetch queue upstream of the MIPS32 pipeline IF stage. Issues sequential word-address reads to instruction memory, buffers returned words with their PCs in a DEPTH-entry FIFO, and presents the head entry to IF as instruction, PC and NPC. A branch redirect from EX/MEM flushes the queue, discards any in-flight response, and restarts fetch at the target.

---
 rtl/mips32_prefetch_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mips32_prefetch_queue.sv
//------------------------------------------------------------------------------
// mips32_prefetch_queue : sequential instruction prefetch FIFO ahead of IF;
//                         optional HLT stop via PREFETCH_HLT_STOP_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips32_prefetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 10,
   parameter int DW    = 32
) (
   input  logic                         clk1,
   input  logic                         rst_n,
   output logic                         mem_req,
   output logic [AW-1:0]                mem_addr,
   input  logic                         mem_gnt,
   input  logic                         mem_rvalid,
   input  logic [DW-1:0]                mem_rdata,
   output logic                         if_valid,
   input  logic                         if_ready,
   output logic [DW-1:0]                if_instr,
   output logic [AW-1:0]                if_pc,
   output logic [AW-1:0]                if_npc,
   input  logic                         redir_valid,
   input  logic [AW-1:0]                redir_pc,
   input  logic                         halt_i,
   output logic [$clog2(DEPTH+1)-1:0]   q_count
);

   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = $clog2(DEPTH+1);

   logic [AW-1:0]   r_fetch_pc;
   logic [AW-1:0]   r_req_pc;
   logic            r_outstanding;
   logic            r_drop;
   logic            r_stopped;
   logic [c_PW-1:0] r_rd_ptr;
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_CW-1:0] r_count;
   logic [DW-1:0]   r_instr_mem [DEPTH];
   logic [AW-1:0]   r_pc_mem    [DEPTH];

   logic [c_CW-1:0] w_occ;
   logic            w_room;
   logic            w_grant;
   logic            w_resp;
   logic            w_push;
   logic            w_pop;
   logic            w_hlt_in;

   // Occupancy counts the in-flight word so a granted response always has a slot.
   assign w_occ  = r_count + c_CW'(r_outstanding);
   assign w_room = (w_occ < c_CW'(DEPTH));

   assign w_resp = mem_rvalid & r_outstanding;
   assign w_push = w_resp & ~r_drop & ~redir_valid & rst_n;
   assign w_pop  = if_valid & if_ready & ~redir_valid;

`ifdef PREFETCH_HLT_STOP_EN
   // An HLT arriving this cycle must also block the request issued alongside it.
   assign w_hlt_in = w_push & (mem_rdata[DW-1:DW-6] == 6'b111111);
`else
   assign w_hlt_in = 1'b0;
`endif

   assign mem_req  = rst_n & ~redir_valid & ~halt_i & ~r_stopped & ~w_hlt_in
                   & w_room & (~r_outstanding | mem_rvalid);
   assign mem_addr = r_fetch_pc;
   assign w_grant  = mem_req & mem_gnt;

   assign if_valid = (r_count != '0);
   assign if_instr = if_valid ? r_instr_mem[r_rd_ptr] : '0;
   assign if_pc    = if_valid ? r_pc_mem[r_rd_ptr] : '0;
   assign if_npc   = if_valid ? (r_pc_mem[r_rd_ptr] + AW'(1)) : '0;
   assign q_count  = r_count;

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_fetch_pc    <= '0;
         r_req_pc      <= '0;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
         r_stopped     <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (redir_valid) begin
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_fetch_pc    <= redir_pc;
         r_stopped     <= 1'b0;
         // A response landing in the redirect cycle retires the request now.
         r_outstanding <= r_outstanding & ~mem_rvalid;
         r_drop        <= r_outstanding & ~mem_rvalid;
      end else begin
         if (w_grant) begin
            r_req_pc      <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + AW'(1);
            r_outstanding <= 1'b1;
         end else if (w_resp) begin
            r_outstanding <= 1'b0;
         end
         if (w_resp && r_drop) begin
            r_drop <= 1'b0;
         end
         if (w_hlt_in) begin
            r_stopped <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_CW'(1);
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= mem_rdata;
         r_pc_mem[r_wr_ptr]    <= r_req_pc;
      end
   end

endmodule

`default_nettype wire
